weight_fetch: RTL and testbench
===============================

WEIGHT_FETCH -- requirements
Module: weight_fetch

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, is the bank word-address width.
REQ-002 Parameter DATA_OUT_WIDTH, default 64, is the bank word width; bank count is fixed at 16.
REQ-003 clk  input  1  is the single clock; all logic is rising-edge.
REQ-004 rst  input  1  is the synchronous, active-high reset.
REQ-005 start  input  1  pulse that launches a fetch job.
REQ-006 base_addr  input  ADDR_WIDTH  is the first row address, sampled on accepted start.
REQ-007 num_rows  input  ADDR_WIDTH+1  is the row count (0..2^ADDR_WIDTH), sampled on accepted start.
REQ-008 bank_mask  input  16  selects the enabled banks, sampled on accepted start.
REQ-009 read_en  output  16  carries the per-bank read strobes to the weight memory array.
REQ-010 addr_flat  output  16*ADDR_WIDTH  carries the bank addresses, with bank i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 data_in_flat  input  16*DATA_OUT_WIDTH  carries the bank read data, with bank i at bits [i*DATA_OUT_WIDTH +: DATA_OUT_WIDTH].
REQ-012 out_data  output  16*DATA_OUT_WIDTH  is one row of weights toward the PE array.
REQ-013 out_valid / out_ready  output / input  1 / 1  form the output handshake.
REQ-014 out_last  output  1  marks the final row of a job and is valid while out_valid=1.
REQ-015 busy  output  1  is high from accepted start until done.
REQ-016 done  output  1  is a one-cycle pulse when the job completes.

Function
REQ-017 The memory contract SHALL be: data for a read_en[i] asserted in cycle t is valid on data_in_flat in cycle t+1.
REQ-018 The FSM SHALL have states IDLE, FETCH and DRAIN.
REQ-019 start SHALL be accepted only in IDLE; start in FETCH or DRAIN SHALL be ignored.
REQ-020 IDLE->FETCH SHALL occur on accepted start with num_rows>0.
REQ-021 On accepted start with num_rows=0, done SHALL pulse in the next cycle, no read_en is issued, and the FSM stays IDLE.
REQ-022 In FETCH, a row SHALL be issued when occupancy + in_flight < 2, where occupancy is the 2-entry output FIFO count and in_flight is 0 or 1.
REQ-023 A row issue SHALL drive read_en = bank_mask for that cycle and set every bank address to (base_addr + row_idx) mod 2^ADDR_WIDTH.
REQ-024 In cycles with no issue, read_en SHALL be 0 and addr_flat SHALL hold its last value.
REQ-025 The cycle after an issue, the captured row SHALL be pushed into the FIFO, with masked-off lanes forced to 0 and the last flag set if row_idx = num_rows-1.
REQ-026 FETCH->DRAIN SHALL occur in the cycle the final row is issued.
REQ-027 DRAIN->IDLE SHALL occur when the last-flagged entry is popped; done SHALL pulse in that same cycle and busy SHALL drop.
REQ-028 out_valid SHALL equal FIFO non-empty, and out_data/out_last SHALL come from the FIFO head.
REQ-029 A pop SHALL occur when out_valid && out_ready.
REQ-030 A simultaneous push and pop SHALL keep the occupancy unchanged.
REQ-031 The FIFO SHALL never overflow; the issue rule guarantees this.
REQ-032 Head data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-033 With out_ready held high, throughput SHALL be one row per cycle, and the first out_valid SHALL appear 2 cycles after the start cycle.
REQ-034 The address SHALL wrap: base_addr=2^ADDR_WIDTH-1 is followed by address 0.

Reset
REQ-035 While rst=1, state=IDLE, read_en=0, addr_flat=0, FIFO empty, in_flight=0, out_valid=0, out_last=0, out_data=0, busy=0 and done=0.
REQ-036 rst asserted mid-job SHALL abort the job, discarding in-flight data and FIFO contents, and SHALL not produce a done pulse.

Verification
REQ-037 start, base=5, rows=3, mask=FFFF, ready=1 -> read_en=FFFF at t+1..t+3 with addr 5,6,7; out_valid at t+2..t+4; out_last at t+4; done at t+4.
REQ-038 rows=4, ready=0 for 6 cycles, then ready=1 -> exactly 2 issues before the stall, head stable, no lost or duplicated rows, order 0..3.
REQ-039 mask=0x0005 -> only read_en[0] and read_en[2] toggle; out_data lanes 1, 3..15 = 0.
REQ-040 base=1023, rows=2 -> addresses 1023 then 0.
REQ-041 rows=0 -> done one cycle after start, read_en never asserted, busy stays 0.
REQ-042 rst during DRAIN with 2 rows queued -> out_valid=0 next cycle, no done; a new start then runs normally.

Source files
------------

// File: rtl/weight_fetch_if.sv
// Job, memory and row-stream signals of the weight fetch engine.
interface weight_fetch_if #(
   parameter int ADDR_WIDTH     = 10,
   parameter int DATA_OUT_WIDTH = 64
);
   logic                         start;
   logic [ADDR_WIDTH-1:0]        base_addr;
   logic [ADDR_WIDTH:0]          num_rows;
   logic [15:0]                  bank_mask;
   logic [15:0]                  read_en;
   logic [16*ADDR_WIDTH-1:0]     addr_flat;
   logic [16*DATA_OUT_WIDTH-1:0] data_in_flat;
   logic [16*DATA_OUT_WIDTH-1:0] out_data;
   logic                         out_valid;
   logic                         out_ready;
   logic                         out_last;
   logic                         busy;
   logic                         done;

   modport master (
      output start, base_addr, num_rows, bank_mask,
      output data_in_flat, out_ready,
      input  read_en, addr_flat, out_data,
      input  out_valid, out_last, busy, done
   );

   modport slave (
      input  start, base_addr, num_rows, bank_mask,
      input  data_in_flat, out_ready,
      output read_en, addr_flat, out_data,
      output out_valid, out_last, busy, done
   );
endinterface

// File: rtl/weight_fetch.sv
// Weight fetch engine: reads rows across 16 weight banks and streams
// them to the PE array through a 2-entry fall-through FIFO.
module weight_fetch #(
   parameter int ADDR_WIDTH     = 10,
   parameter int DATA_OUT_WIDTH = 64
) (
   input  logic          clk,
   input  logic          rst,
   weight_fetch_if.slave bus
);
   localparam int AW = ADDR_WIDTH;
   localparam int DW = DATA_OUT_WIDTH;
   localparam int NB = 16;
   localparam int RW = NB * DW;
   localparam logic [AW:0] ONE = (AW+1)'(1);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] base_q, base_d;
   logic [AW:0]   rows_q, rows_d;
   logic [NB-1:0] mask_q, mask_d;
   logic [AW:0]   nxt_q, nxt_d;
   logic          rd_q, rd_d;
   logic          cur_last_q, cur_last_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          fly_q, fly_d;
   logic          fly_last_q, fly_last_d;
   logic          zdone_q, zdone_d;
   logic [1:0]    cnt_q, cnt_d;
   logic          wp_q, wp_d;
   logic          rp_q, rp_d;
   logic [RW-1:0] mem_q [2];
   logic [RW-1:0] mem_d [2];
   logic [1:0]    mlast_q, mlast_d;

   logic [RW-1:0] push_data;
   logic [RW-1:0] head_data;
   logic          head_last;
   logic          empty;
   logic          valid;
   logic          pop;
   logic          st;
   logic          dq;
   logic [AW:0]   idx;

   always_comb begin
      for (int i = 0; i < NB; i++) begin
         push_data[i*DW +: DW] =
            mask_q[i] ? bus.data_in_flat[i*DW +: DW] : '0;
      end
   end

   // An empty FIFO passes the arriving row straight to the head.
   always_comb begin
      empty     = (cnt_q == 2'd0);
      head_data = empty ? push_data : mem_q[rp_q];
      head_last = empty ? fly_last_q : mlast_q[rp_q];
      valid     = !empty || fly_q;
      pop       = valid && bus.out_ready;
      st        = fly_q && !(empty && pop);
      dq        = pop && !empty;
   end

   always_comb begin
      mem_d   = mem_q;
      mlast_d = mlast_q;
      if (st) begin
         mem_d[wp_q]   = push_data;
         mlast_d[wp_q] = fly_last_q;
      end
      cnt_d = cnt_q + {1'b0, st} - {1'b0, dq};
      wp_d  = wp_q ^ st;
      rp_d  = rp_q ^ dq;
   end

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      rows_d     = rows_q;
      mask_d     = mask_q;
      zdone_d    = 1'b0;
      idx        = nxt_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               base_d = bus.base_addr;
               rows_d = bus.num_rows;
               mask_d = bus.bank_mask;
               idx    = '0;
               if (bus.num_rows == '0) begin
                  zdone_d = 1'b1;
               end else begin
                  state_d = FETCH;
               end
            end
         end
         FETCH: begin
            if (rd_q && cur_last_q) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && head_last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Issue next cycle only if the FIFO can absorb every outstanding row.
      fly_d      = rd_q;
      fly_last_d = cur_last_q;
      rd_d       = (state_d == FETCH) &&
                   ((cnt_d + {1'b0, rd_q}) < 2'd2);
      addr_d     = addr_q;
      cur_last_d = cur_last_q;
      nxt_d      = idx;
      if (rd_d) begin
         addr_d     = base_d + idx[AW-1:0];
         cur_last_d = (idx == rows_d - ONE);
         nxt_d      = idx + ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         base_q     <= '0;
         rows_q     <= '0;
         mask_q     <= '0;
         nxt_q      <= '0;
         rd_q       <= 1'b0;
         cur_last_q <= 1'b0;
         addr_q     <= '0;
         fly_q      <= 1'b0;
         fly_last_q <= 1'b0;
         zdone_q    <= 1'b0;
         cnt_q      <= '0;
         wp_q       <= 1'b0;
         rp_q       <= 1'b0;
         mlast_q    <= '0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         rows_q     <= rows_d;
         mask_q     <= mask_d;
         nxt_q      <= nxt_d;
         rd_q       <= rd_d;
         cur_last_q <= cur_last_d;
         addr_q     <= addr_d;
         fly_q      <= fly_d;
         fly_last_q <= fly_last_d;
         zdone_q    <= zdone_d;
         cnt_q      <= cnt_d;
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         mem_q      <= mem_d;
         mlast_q    <= mlast_d;
      end
   end

   always_comb begin
      bus.read_en   = '0;
      bus.addr_flat = '0;
      bus.out_data  = '0;
      bus.out_valid = 1'b0;
      bus.out_last  = 1'b0;
      bus.busy      = 1'b0;
      bus.done      = 1'b0;
      if (!rst) begin
         bus.read_en   = rd_q ? mask_q : '0;
         bus.addr_flat = {NB{addr_q}};
         bus.out_data  = head_data;
         bus.out_valid = valid;
         bus.out_last  = valid && head_last;
         bus.busy      = (state_q != IDLE);
         bus.done      = zdone_q ||
                         ((state_q == DRAIN) && pop && head_last);
      end
   end
endmodule

// File: tb/tb_weight_fetch.sv
// Bench for weight_fetch: bank memory model, row-order model and
// directed jobs with hand-computed expectations.
module tb_weight_fetch;
   localparam int AW = 10;
   localparam int DW = 64;
   localparam int NB = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   weight_fetch_if #(.ADDR_WIDTH(AW), .DATA_OUT_WIDTH(DW)) bus ();

   weight_fetch #(.ADDR_WIDTH(AW), .DATA_OUT_WIDTH(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // job model
   logic [AW-1:0] j_base = '0;
   int            j_rows = 0;
   logic [15:0]   j_mask = '0;
   int            issued = 0;
   int            popped = 0;
   bit            active = 1'b0;
   int            act_from = 0;
   int            zdue = -1;

   int            re_cyc[$];
   int            re_addr[$];
   logic [15:0]   re_val[$];
   int            ov_cyc[$];
   int            pop_cyc[$];
   int            done_cyc[$];
   int            last_cyc[$];
   logic [NB*DW-1:0] first_pop;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] memf(input int b, input int a);
      logic [15:0] lo;
      lo = 16'(a) ^ (16'(b) << 12);
      return {16'hB000 | 16'(b), 16'(a), 16'hC0DE, lo};
   endfunction

   function automatic logic [63:0] exp_lane(input int k, input int i);
      logic [AW-1:0] a;
      a = j_base + AW'(k);
      return j_mask[i] ? memf(i, int'(a)) : 64'h0;
   endfunction

   // bank memory: one-cycle read latency, garbage on unread banks
   initial begin
      logic [15:0]      re;
      logic [NB*AW-1:0] ad;
      bus.data_in_flat = '0;
      forever begin
         @(negedge clk);
         re = bus.read_en;
         ad = bus.addr_flat;
         @(posedge clk);
         #1;
         for (int i = 0; i < NB; i++) begin
            bus.data_in_flat[i*DW +: DW] = re[i] ?
               memf(i, int'(ad[i*AW +: AW])) : {$urandom, $urandom};
         end
      end
   end

   // per-cycle compare against the job model
   initial begin
      logic [AW-1:0] ea;
      bit            exp_done;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_read_en", 64'(bus.read_en), 64'h0);
            chk("rst_addr", 64'(bus.addr_flat == '0), 64'h1);
            chk("rst_valid", 64'(bus.out_valid), 64'h0);
            chk("rst_last", 64'(bus.out_last), 64'h0);
            chk("rst_data", 64'(bus.out_data == '0), 64'h1);
            chk("rst_busy", 64'(bus.busy), 64'h0);
            chk("rst_done", 64'(bus.done), 64'h0);
         end else begin
            exp_done = (cyc == zdue);
            if (bus.read_en != '0) begin
               re_cyc.push_back(cyc);
               re_val.push_back(bus.read_en);
               re_addr.push_back(int'(bus.addr_flat[AW-1:0]));
               chk("read_en", 64'(bus.read_en), 64'(j_mask));
               chk("issue_in_job", 64'(issued < j_rows), 64'h1);
               ea = j_base + AW'(issued);
               for (int i = 0; i < NB; i++)
                  chk("addr", 64'(bus.addr_flat[i*AW +: AW]), 64'(ea));
               issued++;
               chk("fifo_bound", 64'(issued - popped <= 2), 64'h1);
            end else if (issued > 0) begin
               ea = j_base + AW'(issued - 1);
               for (int i = 0; i < NB; i++)
                  chk("addr_hold", 64'(bus.addr_flat[i*AW +: AW]),
                      64'(ea));
            end
            if (bus.out_valid) begin
               ov_cyc.push_back(cyc);
               chk("valid_has_row", 64'(popped < issued), 64'h1);
               for (int i = 0; i < NB; i++)
                  chk("out_data", bus.out_data[i*DW +: DW],
                      exp_lane(popped, i));
               chk("out_last", 64'(bus.out_last),
                   64'(popped == j_rows - 1));
               if (bus.out_last) last_cyc.push_back(cyc);
               if (bus.out_ready) begin
                  if (popped == 0) first_pop = bus.out_data;
                  if (popped == j_rows - 1) exp_done = 1'b1;
                  popped++;
                  pop_cyc.push_back(cyc);
               end
            end
            chk("done", 64'(bus.done), 64'(exp_done));
            chk("busy", 64'(bus.busy), 64'(active && cyc >= act_from));
            if (bus.done) begin
               done_cyc.push_back(cyc);
               active = 1'b0;
            end
         end
      end
   end

   task automatic clear_logs();
      re_cyc.delete();
      re_addr.delete();
      re_val.delete();
      ov_cyc.delete();
      pop_cyc.delete();
      done_cyc.delete();
      last_cyc.delete();
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic [AW-1:0] b, input int rows,
                            input logic [15:0] m, output int t);
      clear_logs();
      j_base = b;
      j_rows = rows;
      j_mask = m;
      issued = 0;
      popped = 0;
      bus.start = 1'b1;
      bus.base_addr = b;
      bus.num_rows = (AW+1)'(rows);
      bus.bank_mask = m;
      t = cyc;
      if (rows == 0) begin
         zdue = cyc + 1;
      end else begin
         active = 1'b1;
         act_from = cyc + 1;
      end
      step(1);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int lim);
      int n;
      n = 0;
      while (done_cyc.size() == 0 && n < lim) begin
         step(1);
         n++;
      end
      chk({nm, "_done_seen"}, 64'(done_cyc.size() > 0), 64'h1);
      step(2);
   endtask

   initial begin
      int t;
      bus.start = 1'b0;
      bus.base_addr = '0;
      bus.num_rows = '0;
      bus.bank_mask = '0;
      bus.out_ready = 1'b1;
      rst = 1'b1;
      step(3);
      rst = 1'b0;
      step(2);

      // A: base 5, 3 rows, all banks, ready high
      start_job(10'd5, 3, 16'hFFFF, t);
      wait_done("A", 40);
      chk("A_issues", 64'(re_cyc.size()), 64'd3);
      for (int k = 0; k < re_cyc.size(); k++) begin
         chk("A_issue_cyc", 64'(re_cyc[k] - t), 64'(k + 1));
         chk("A_issue_addr", 64'(re_addr[k]), 64'(5 + k));
      end
      chk("A_valids", 64'(ov_cyc.size()), 64'd3);
      for (int k = 0; k < ov_cyc.size(); k++)
         chk("A_valid_cyc", 64'(ov_cyc[k] - t), 64'(k + 2));
      chk("A_last_cyc", 64'(last_cyc.size() == 1 && last_cyc[0] == t + 4),
          64'h1);
      chk("A_done_cyc", 64'(done_cyc[0] - t), 64'd4);
      chk("A_lane3", first_pop[3*DW +: DW], 64'hB003_0005_C0DE_3005);

      // B: 4 rows with output stalled, plus a start that must be ignored
      bus.out_ready = 1'b0;
      start_job(10'd100, 4, 16'hFFFF, t);
      step(2);
      bus.start = 1'b1;
      bus.base_addr = 10'd500;
      bus.num_rows = 11'd1;
      step(1);
      bus.start = 1'b0;
      step(3);
      chk("B_issues_stalled", 64'(re_cyc.size()), 64'd2);
      chk("B_no_pop_stalled", 64'(pop_cyc.size()), 64'd0);
      bus.out_ready = 1'b1;
      wait_done("B", 40);
      chk("B_issues", 64'(re_cyc.size()), 64'd4);
      chk("B_pops", 64'(pop_cyc.size()), 64'd4);
      chk("B_first_valid", 64'(ov_cyc[0] - t), 64'd2);

      // C: only banks 0 and 2 enabled
      start_job(10'd20, 3, 16'h0005, t);
      wait_done("C", 40);
      for (int k = 0; k < re_val.size(); k++)
         chk("C_read_en", 64'(re_val[k]), 64'h0005);
      chk("C_lane0", first_pop[0 +: DW], 64'hB000_0014_C0DE_0014);
      chk("C_lane1", first_pop[1*DW +: DW], 64'h0);
      chk("C_lane2", first_pop[2*DW +: DW], 64'hB002_0014_C0DE_2014);
      chk("C_lane15", first_pop[15*DW +: DW], 64'h0);

      // D: address wrap
      start_job(10'd1023, 2, 16'hFFFF, t);
      wait_done("D", 40);
      chk("D_issues", 64'(re_addr.size()), 64'd2);
      chk("D_addr0", 64'(re_addr.size() > 0 ? re_addr[0] : -1), 64'd1023);
      chk("D_addr1", 64'(re_addr.size() > 1 ? re_addr[1] : -1), 64'd0);

      // E: zero-row job
      start_job(10'd9, 0, 16'hFFFF, t);
      wait_done("E", 10);
      chk("E_done_cyc", 64'(done_cyc[0] - t), 64'd1);
      chk("E_no_reads", 64'(re_cyc.size()), 64'd0);

      // F: reset while draining two queued rows
      bus.out_ready = 1'b0;
      start_job(10'd300, 2, 16'hFFFF, t);
      step(4);
      chk("F_queued", 64'(issued - popped), 64'd2);
      rst = 1'b1;
      active = 1'b0;
      issued = 0;
      popped = 0;
      j_rows = 0;
      clear_logs();
      step(1);
      rst = 1'b0;
      @(negedge clk);
      chk("F_valid_after_rst", 64'(bus.out_valid), 64'h0);
      chk("F_busy_after_rst", 64'(bus.busy), 64'h0);
      step(3);
      chk("F_no_done", 64'(done_cyc.size()), 64'd0);
      chk("F_no_valid", 64'(ov_cyc.size()), 64'd0);

      // G: normal job after the abort
      bus.out_ready = 1'b1;
      start_job(10'd7, 3, 16'hFFFF, t);
      wait_done("G", 40);
      chk("G_issues", 64'(re_cyc.size()), 64'd3);
      chk("G_pops", 64'(pop_cyc.size()), 64'd3);
      chk("G_done_cyc", 64'(done_cyc[0] - t), 64'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
